// File: rtl/calc_pkg.sv
// Shared calculator types, default width and counter-width helper.
// Used by the sequential divider and its combinational step.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  localparam int CALC_WIDTH = 4;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, try subtract.
// Ports: r (partial remainder), bit_in, b -> r_next, q_bit.
module div_step
  import calc_pkg::*;
#(
  parameter int N = CALC_WIDTH
) (
  input  logic [N:0]   r,
  input  logic         bit_in,
  input  logic [N-1:0] b,
  output logic [N:0]   r_next,
  output logic         q_bit
);

  logic [N:0] sh;
  logic [N:0] bx;

  // r is always < b on entry, so its top bit is zero and the
  // shift cannot lose information.
  assign sh     = (r << 1) | {{N{1'b0}}, bit_in};
  assign bx     = {1'b0, b};
  assign q_bit  = (sh >= bx);
  assign r_next = q_bit ? (sh - bx) : sh;

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst, start, a, b -> busy, done, quotient, remainder_mod,
// error_div, error_mod. Option macro: SEQ_DIV_EARLY_EXIT_EN (a < b skip).
module seq_divider
  import calc_pkg::*;
#(
  parameter int N = CALC_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder_mod,
  output logic         error_div,
  output logic         error_mod
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  div_state_t state;
  div_state_t state_next;

  logic [N:0]    r;
  logic [N-1:0]  dvd;
  logic [N-1:0]  dvs;
  logic [CW-1:0] cnt;

  logic [N:0] r_next;
  logic       q_bit;
  logic       accept;
  logic       zero_div;
  logic       skip;

  div_step #(.N(N)) u_step (
    .r      (r),
    .bit_in (dvd[N-1]),
    .b      (dvs),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign accept   = start && (state != CALC);
  assign zero_div = (b == '0);

`ifdef SEQ_DIV_EARLY_EXIT_EN
  assign skip = !zero_div && (a < b);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (!start) begin
          state_next = IDLE;
        end else if (zero_div || skip) begin
          state_next = DONE;
        end else begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (cnt == LAST) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r             <= '0;
      dvd           <= '0;
      dvs           <= '0;
      cnt           <= '0;
      quotient      <= '0;
      remainder_mod <= '0;
      error_div     <= 1'b0;
      error_mod     <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        quotient      <= '1;
        remainder_mod <= a;
        error_div     <= 1'b1;
        error_mod     <= 1'b1;
      end else if (skip) begin
        quotient      <= '0;
        remainder_mod <= a;
        error_div     <= 1'b0;
        error_mod     <= 1'b0;
      end else begin
        dvd       <= a;
        dvs       <= b;
        r         <= '0;
        cnt       <= '0;
        error_div <= 1'b0;
        error_mod <= 1'b0;
      end
    end else if (state == CALC) begin
      // dvd shifts out dividend bits at the top and collects
      // quotient bits at the bottom.
      r   <= r_next;
      dvd <= {dvd[N-2:0], q_bit};
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        quotient      <= {dvd[N-2:0], q_bit};
        remainder_mod <= r_next[N-1:0];
      end
    end
  end

endmodule
